hop_route_sched: RTL

- Synchronous scheduler that shares one 1-of-4 hop-decrement/route-decision unit among NREQ router input ports.
- Each requester presents a head-flit routing header: X and Y hop digits, each 1-of-4 coded with value 0..3, plus direction signs.
- The block round-robin arbitrates, applies XY dimension-ordered decrement, selects the output port, and registers the result behind a valid/ready handshake.
- Sits between the input buffers and the switch allocator of a synchronous router tile.

---
 rtl/hop_route_sched.sv | 136 +++++++++++++
 1 files changed

// File: rtl/hop_route_sched.sv
// Shared XY hop-decrement / route-decision unit. Requesting input ports take turns
// through a round-robin arbiter, and one registered result is produced per grant.
module hop_route_sched #(
    parameter int NREQ = 5,
    parameter int SW   = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_vld,
    output logic [NREQ-1:0]   req_rdy,
    input  logic [4*NREQ-1:0] req_x,
    input  logic [4*NREQ-1:0] req_y,
    input  logic [NREQ-1:0]   req_xs,
    input  logic [NREQ-1:0]   req_ys,
    output logic              out_vld,
    input  logic              out_rdy,
    output logic [SW-1:0]     out_src,
    output logic [3:0]        out_x,
    output logic [3:0]        out_y,
    output logic [4:0]        out_port,
    output logic              err
);

    localparam logic [4:0] PORT_L = 5'b00001;
    localparam logic [4:0] PORT_N = 5'b00010;
    localparam logic [4:0] PORT_E = 5'b00100;
    localparam logic [4:0] PORT_S = 5'b01000;
    localparam logic [4:0] PORT_W = 5'b10000;

    logic          out_vld_q, out_vld_d;
    logic [SW-1:0] out_src_q, out_src_d;
    logic [3:0]    out_x_q,   out_x_d;
    logic [3:0]    out_y_q,   out_y_d;
    logic [4:0]    out_port_q, out_port_d;
    logic          err_q,     err_d;
    logic [SW-1:0] ptr_q,     ptr_d;

    logic          slot_free;
    logic          found;
    logic          gnt;
    logic [SW-1:0] gnt_idx;
    logic [3:0]    gnt_x, gnt_y;
    logic          gnt_xs, gnt_ys;
    logic          legal;

    // Round-robin search starting at ptr_q, wrapping modulo NREQ.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        slot_free = !out_vld_q || out_rdy;
        found     = 1'b0;
        gnt_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            int j;
            j = int'(ptr_q) + k;
            if (j >= NREQ) j = j - NREQ;
            if (!found && req_vld[j]) begin
                found   = 1'b1;
                gnt_idx = SW'(j);
            end
        end
        gnt     = slot_free && found && !rst;
        req_rdy = gnt ? (NREQ'(1) << gnt_idx) : '0;
    end

    always_comb begin
        gnt_x  = req_x[int'(gnt_idx)*4 +: 4];
        gnt_y  = req_y[int'(gnt_idx)*4 +: 4];
        gnt_xs = req_xs[gnt_idx];
        gnt_ys = req_ys[gnt_idx];
        legal  = $onehot(gnt_x) && $onehot(gnt_y);
    end

    always_comb begin
        out_vld_d  = out_vld_q;
        out_src_d  = out_src_q;
        out_x_d    = out_x_q;
        out_y_d    = out_y_q;
        out_port_d = out_port_q;
        err_d      = err_q;
        ptr_d      = ptr_q;

        if (slot_free) begin
            // A drained slot with nothing legal to load goes empty.
            out_vld_d = 1'b0;
            if (gnt) begin
                ptr_d = (int'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + 1'b1;
                if (legal) begin
                    out_vld_d = 1'b1;
                    out_src_d = gnt_idx;
                    out_x_d   = gnt_x;
                    out_y_d   = gnt_y;
                    if (gnt_x != 4'b0001) begin
                        out_x_d    = gnt_x >> 1;
                        out_port_d = gnt_xs ? PORT_W : PORT_E;
                    end else if (gnt_y != 4'b0001) begin
                        out_y_d    = gnt_y >> 1;
                        out_port_d = gnt_ys ? PORT_S : PORT_N;
                    end else begin
                        out_port_d = PORT_L;
                    end
                end else begin
                    err_d = 1'b1;
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_vld_q  <= 1'b0;
            out_src_q  <= '0;
            out_x_q    <= '0;
            out_y_q    <= '0;
            out_port_q <= '0;
            err_q      <= 1'b0;
            ptr_q      <= '0;
        end else begin
            out_vld_q  <= out_vld_d;
            out_src_q  <= out_src_d;
            out_x_q    <= out_x_d;
            out_y_q    <= out_y_d;
            out_port_q <= out_port_d;
            err_q      <= err_d;
            ptr_q      <= ptr_d;
        end
    end

    assign out_vld  = out_vld_q;
    assign out_src  = out_src_q;
    assign out_x    = out_x_q;
    assign out_y    = out_y_q;
    assign out_port = out_port_q;
    assign err      = err_q;

endmodule
